// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the memory responder slice: FSM state encoding,
//   physical memory base address and byte-mask width.
//   No ports (package).
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] PMEM_BASE = 32'h8000_0000;
    localparam int          MASK_W    = 4;
    localparam int          CNT_W     = 4;   // holds LATENCY-1 for LATENCY up to 15

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response handshake bundle between the core (master) and the
//   memory responder (slave).
//   req_valid/req_ready   : request handshake
//   req_addr/req_wen      : byte address, 1 = write
//   req_wdata/req_wmask   : write data, per-byte-lane enables
//   resp_valid/resp_ready : response handshake
//   resp_rdata            : read data (0 for write responses)
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              req_wen;
    logic [31:0]       req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array
//   Word-organised backing store, DEPTH x 32 bits.
//   clk   in : clock, rising edge
//   we    in : write enable (commits on the rising edge)
//   waddr in : word index for the write
//   wdata in : write data
//   wmask in : byte-lane enables for the write
//   raddr in : word index for the read
//   rdata out: word at raddr (combinational; the responder registers it)
module mem_array
    import mem_responder_pkg::*;
#(
    parameter  int DEPTH = 4096,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [31:0]       wdata,
    input  logic [MASK_W-1:0] wmask,
    input  logic [AW-1:0]     raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder: accepts one read/write request at a time and
//   returns a response LATENCY cycles after acceptance.
//   clk in : clock, rising edge
//   rst in : asynchronous reset, active-high
//   bus     : mem_responder_if.slave (request and response channels)
//   Parameters: LATENCY (1..15), DEPTH (words, internal array only), BASE.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | req_ready=1, waiting for a request
//   WAIT  | request latched, counting down the access latency
//   RESP  | resp_valid=1, holding rdata until resp_ready
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          LATENCY = 2,
    parameter int          DEPTH   = 4096,
    parameter logic [31:0] BASE    = PMEM_BASE
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic             wen_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [31:0]      rdata_q;

    logic             accept;
    logic             enter_resp;
    logic [31:0]      dec_addr;
    logic             dec_wen;

    assign accept = (state == IDLE) && bus.req_valid;

    // In IDLE the live request is decoded so LATENCY==1 can capture on the
    // acceptance edge; later the latched fields are used.
    assign dec_addr = (state == IDLE) ? bus.req_addr : addr_q;
    assign dec_wen  = (state == IDLE) ? bus.req_wen  : wen_q;

    assign enter_resp = (LATENCY == 1) ? accept
                                       : ((state == WAIT) && (cnt == CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        wen_q       <= bus.req_wen;
                        cnt         <= CNT_W'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Leaving on cnt==1 makes the counter hit 0 on the RESP edge.
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;

    logic [31:0] off;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] mem_rdata;
    logic [31:0] rd_word;

    // Addresses below BASE wrap to a large offset and fail the same compare.
    assign off      = dec_addr - BASE;
    assign in_range = off < LIMIT;
    assign idx      = off[AW+1:2];

    mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (accept && bus.req_wen && in_range),
        .waddr (idx),
        .wdata (bus.req_wdata),
        .wmask (bus.req_wmask),
        .raddr (idx),
        .rdata (mem_rdata)
    );

    assign rd_word = in_range ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             rdata_q <= '0;
        else if (enter_resp) rdata_q <= dec_wen ? '0 : rd_word;
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Three responders (LATENCY 2/1/3) share the stimulus bus; sel routes
//   req_valid to one of them and picks which outputs are observed.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;

    logic [1:0]  sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_ready;

    logic        v_ready [3];
    logic        v_valid [3];
    logic [31:0] v_rdata [3];
    int          lat_of  [3] = '{2, 1, 3};

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if if_a ();
    mem_responder_if if_b ();
    mem_responder_if if_c ();

    mem_responder #(.LATENCY(2))              u_a (.clk(clk), .rst(rst), .bus(if_a));
    mem_responder #(.LATENCY(1), .DEPTH(16))  u_b (.clk(clk), .rst(rst), .bus(if_b));
    mem_responder #(.LATENCY(3), .DEPTH(16))  u_c (.clk(clk), .rst(rst), .bus(if_c));

    assign if_a.req_valid = req_valid && (sel == 2'd0);
    assign if_b.req_valid = req_valid && (sel == 2'd1);
    assign if_c.req_valid = req_valid && (sel == 2'd2);
    assign if_a.req_addr = req_addr;   assign if_b.req_addr = req_addr;   assign if_c.req_addr = req_addr;
    assign if_a.req_wen = req_wen;     assign if_b.req_wen = req_wen;     assign if_c.req_wen = req_wen;
    assign if_a.req_wdata = req_wdata; assign if_b.req_wdata = req_wdata; assign if_c.req_wdata = req_wdata;
    assign if_a.req_wmask = req_wmask; assign if_b.req_wmask = req_wmask; assign if_c.req_wmask = req_wmask;
    assign if_a.resp_ready = resp_ready;
    assign if_b.resp_ready = resp_ready;
    assign if_c.resp_ready = resp_ready;

    assign v_ready[0] = if_a.req_ready;  assign v_valid[0] = if_a.resp_valid;  assign v_rdata[0] = if_a.resp_rdata;
    assign v_ready[1] = if_b.req_ready;  assign v_valid[1] = if_b.resp_valid;  assign v_rdata[1] = if_b.resp_rdata;
    assign v_ready[2] = if_c.req_ready;  assign v_valid[2] = if_c.resp_valid;  assign v_rdata[2] = if_c.resp_rdata;

    typedef struct {
        int          s;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One complete transaction on DUT s; hold>0 stalls resp_ready for that
    // many cycles and pulses req_valid once during the stall.
    task automatic txn(input int s, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] exp, input int hold);
        int c;
        int first;
        int budget;
        logic [31:0] held;
        sel = 2'(s);
        @(negedge clk);
        budget = 0;
        while (!v_ready[s] && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("req_ready before request", 32'(v_ready[s]), 32'd1);
        req_addr   = a;
        req_wen    = w;
        req_wdata  = d;
        req_wmask  = m;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        c = cyc;
        exp_q.push_back(exp);
        @(negedge clk);
        req_valid = 1'b0;
        budget = 0;
        while (!v_valid[s] && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        first = cyc;
        check("latency", 32'(first - c), 32'(lat_of[s]));
        held = v_rdata[s];
        for (int i = 0; i < hold; i++) begin
            check("stall resp_valid", 32'(v_valid[s]), 32'd1);
            check("stall rdata", v_rdata[s], held);
            check("stall req_ready", 32'(v_ready[s]), 32'd0);
            if (i == 2) begin
                req_valid = 1'b1;
                req_addr  = a ^ 32'h4;
                req_wen   = 1'b0;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        if (exp_q.size() == 0) check("scoreboard empty", 32'd1, 32'd0);
        else                   check("rdata", v_rdata[s], exp_q.pop_front());
        @(negedge clk);
        check("resp_valid after handshake", 32'(v_valid[s]), 32'd0);
        check("req_ready after handshake", 32'(v_ready[s]), 32'd1);
    endtask

    initial begin
        logic [31:0] tp_addr [4];
        logic [31:0] tp_exp  [4];
        int n_acc, n_resp, first_acc, prev_acc, last_resp, seen;

        sel        = 2'd0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wen    = 1'b0;
        req_wdata  = '0;
        req_wmask  = '0;
        resp_ready = 1'b1;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset req_ready", 32'(v_ready[k]), 32'd1);
            check("reset resp_valid", 32'(v_valid[k]), 32'd0);
            check("reset resp_rdata", v_rdata[k], 32'd0);
        end
        rst = 1'b0;

        // u_a: LATENCY=2, DEPTH=4096
        vt.push_back('{0, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'hF, 32'h0});
        vt.push_back('{0, 32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'h1234_5678});
        vt.push_back('{0, 32'h8000_0010, 1'b1, 32'hAABB_CCDD, 4'h5, 32'h0});
        vt.push_back('{0, 32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'h12BB_56DD});
        vt.push_back('{0, 32'h8000_0014, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0});
        vt.push_back('{0, 32'h8000_0014, 1'b1, 32'h1111_1111, 4'h0, 32'h0});
        vt.push_back('{0, 32'h8000_0014, 1'b0, 32'h0,         4'h0, 32'hCAFE_F00D});
        vt.push_back('{0, 32'h7FFF_FFFC, 1'b0, 32'h0,         4'h0, 32'h0});
        vt.push_back('{0, 32'h8000_0000, 1'b1, 32'h0102_0304, 4'hF, 32'h0});
        vt.push_back('{0, 32'h8000_4000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vt.push_back('{0, 32'h8000_4000, 1'b0, 32'h0,         4'h0, 32'h0});
        vt.push_back('{0, 32'h8000_0000, 1'b0, 32'h0,         4'h0, 32'h0102_0304});
        vt.push_back('{0, 32'h8000_3FFC, 1'b1, 32'h55AA_55AA, 4'hF, 32'h0});
        vt.push_back('{0, 32'h8000_3FFF, 1'b0, 32'h0,         4'h0, 32'h55AA_55AA});
        // u_b: LATENCY=1, DEPTH=16
        vt.push_back('{1, 32'h8000_0000, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0});
        vt.push_back('{1, 32'h8000_0004, 1'b1, 32'h1122_3344, 4'hF, 32'h0});
        vt.push_back('{1, 32'h8000_0008, 1'b1, 32'h5566_7788, 4'hF, 32'h0});
        vt.push_back('{1, 32'h8000_000C, 1'b1, 32'h99AA_BBCC, 4'hF, 32'h0});
        vt.push_back('{1, 32'h8000_0040, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0});
        vt.push_back('{1, 32'h8000_0040, 1'b0, 32'h0,         4'h0, 32'h0});
        vt.push_back('{1, 32'h8000_0000, 1'b0, 32'h0,         4'h0, 32'hA5A5_A5A5});
        // u_c: LATENCY=3, DEPTH=16
        vt.push_back('{2, 32'h8000_0008, 1'b1, 32'h7766_5544, 4'hF, 32'h0});
        vt.push_back('{2, 32'h8000_0008, 1'b1, 32'hEE00_0000, 4'h8, 32'h0});
        vt.push_back('{2, 32'h8000_0008, 1'b0, 32'h0,         4'h0, 32'hEE66_5544});

        foreach (vt[i]) txn(vt[i].s, vt[i].a, vt[i].w, vt[i].d, vt[i].m, vt[i].exp, 0);

        // Backpressure: 5-cycle stall in RESP on u_a
        txn(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h12BB_56DD, 5);

        // Back-to-back reads on LATENCY=1 with resp_ready tied high
        tp_addr = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
        tp_exp  = '{32'hA5A5_A5A5, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
        sel = 2'd1;
        resp_ready = 1'b1;
        n_acc = 0; n_resp = 0; first_acc = 0; prev_acc = 0; last_resp = -100;
        @(negedge clk);
        for (int k = 0; k < 30 && n_resp < 4; k++) begin
            if (v_valid[1]) begin
                check("b2b rdata", v_rdata[1], exp_q.pop_front());
                n_resp++;
                last_resp = cyc;
            end
            if (v_ready[1] && n_acc < 4) begin
                req_addr  = tp_addr[n_acc];
                req_wen   = 1'b0;
                req_wmask = 4'h0;
                req_valid = 1'b1;
                exp_q.push_back(tp_exp[n_acc]);
                if (n_acc == 0) first_acc = cyc;
                else            check("b2b accept spacing", 32'(cyc - prev_acc), 32'd2);
                prev_acc = cyc;
                n_acc++;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b responses", 32'(n_resp), 32'd4);
        check("b2b span cycles", 32'(last_resp - first_acc + 1), 32'd8);

        // Reset in the middle of WAIT on u_c (LATENCY=3); the write stays committed
        sel = 2'd2;
        @(negedge clk);
        req_addr  = 32'h8000_0004;
        req_wen   = 1'b1;
        req_wdata = 32'h0BAD_F00D;
        req_wmask = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-WAIT reset resp_valid", 32'(v_valid[2]), 32'd0);
        check("mid-WAIT reset req_ready", 32'(v_ready[2]), 32'd1);
        check("mid-WAIT reset rdata", v_rdata[2], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (v_valid[2]) seen++;
            @(negedge clk);
        end
        check("no response after reset", 32'(seen), 32'd0);
        check("req_ready after reset", 32'(v_ready[2]), 32'd1);
        txn(2, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 0);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
